i2s_capture_ctrl: RTL and testbench

Sequencer that drives one EF_I2S receiver through a bounded capture. On `start` it enables the receiver, flushes the FIFO, optionally waits for voice activity (`vad_flag`), then drains exactly `sample_count` FIFO words onto a valid/ready stream. It reports completion, timeout and overrun status. It sits between the EF_I2S FIFO read port and a downstream DMA or stream consumer.

---
 rtl/i2s_cap_pkg.sv | 14 +
 rtl/i2s_cap_ostage.sv | 30 +++
 rtl/i2s_capture_ctrl.sv | 137 +++++++++++++
 tb/tb_i2s_capture_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_cap_pkg.sv
// Shared types and defaults for the I2S capture sequencer.
// State encoding and counter widths.
package i2s_cap_pkg;

  localparam int CW_DEF = 16;
  localparam int TW_DEF = 24;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLUSH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/i2s_cap_ostage.sv
// Single-entry output register for the capture stream.
// clr drops the held word immediately.
module i2s_cap_ostage
  import i2s_cap_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] din,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_capture_ctrl.sv
// Bounded-capture sequencer for one EF_I2S receiver.
// Flush, optional VAD wait, then drain sample_count words.
module i2s_capture_ctrl
  import i2s_cap_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          vad_trig_en,
  input  logic [CW-1:0] sample_count,
  input  logic [TW-1:0] timeout,
  input  logic          vad_flag,
  input  logic          fifo_empty,
  input  logic          fifo_full,
  input  logic [31:0]   fifo_rdata,
  output logic          i2s_en,
  output logic          fifo_en,
  output logic          fifo_flush,
  output logic          fifo_rd,
  output logic          m_valid,
  output logic [31:0]   m_data,
  input  logic          m_ready,
  output logic          busy,
  output logic          done,
  output logic          timed_out,
  output logic          overrun
);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] remaining;
  logic [TW-1:0] tcnt;
  logic          accept;
  logic          slot;
  logic          rem_zero;
  logic          tmo_hit;

  assign accept   = (state == ST_IDLE) && start
                 && (|sample_count) && !abort;
  assign slot     = !m_valid || m_ready;
  assign rem_zero = (remaining == '0);
  assign tmo_hit  = (|timeout)
                 && (tcnt == timeout - TW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == ST_IDLE):
        if (accept) state_nxt = ST_FLUSH;
      (state == ST_FLUSH):
        state_nxt = vad_trig_en ? ST_WAIT : ST_CAP;
      (state == ST_WAIT):
        if (vad_flag)     state_nxt = ST_CAP;
        else if (tmo_hit) state_nxt = ST_DONE;
      (state == ST_CAP):
        if (rem_zero && slot) state_nxt = ST_DONE;
      (state == ST_DONE):
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_comb begin
    i2s_en     = 1'b0;
    fifo_en    = 1'b0;
    fifo_flush = 1'b0;
    fifo_rd    = 1'b0;
    done       = 1'b0;
    unique case (1'b1)
      (state == ST_FLUSH): begin
        i2s_en     = 1'b1;
        fifo_flush = 1'b1;
      end
      (state == ST_WAIT):
        i2s_en = 1'b1;
      (state == ST_CAP): begin
        i2s_en  = 1'b1;
        fifo_en = 1'b1;
        fifo_rd = !fifo_empty && !rem_zero && slot;
      end
      (state == ST_DONE): begin
        i2s_en = 1'b1;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      tcnt      <= '0;
      timed_out <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept)       remaining <= sample_count;
      else if (fifo_rd) remaining <= remaining - CW'(1);
      tcnt <= (state == ST_WAIT) ? tcnt + TW'(1) : '0;
      if (accept) begin
        timed_out <= 1'b0;
        overrun   <= 1'b0;
      end else begin
        // abort and a late VAD both outrank the timeout
        if (state == ST_WAIT && tmo_hit
            && !vad_flag && !abort)
          timed_out <= 1'b1;
        if (state == ST_CAP && fifo_full)
          overrun <= 1'b1;
      end
    end
  end

  i2s_cap_ostage u_ostage (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .load  (fifo_rd),
    .din   (fifo_rdata),
    .ready (m_ready),
    .valid (m_valid),
    .data  (m_data)
  );

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Directed bench for i2s_capture_ctrl.
// Includes a small first-word-fall-through FIFO model.
module tb_i2s_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, vad_trig_en, vad_flag;
  logic [15:0] sample_count;
  logic [23:0] timeout;
  logic        fifo_empty = 1'b1;
  logic        fifo_full;
  logic [31:0] fifo_rdata = 32'h0;
  logic        i2s_en, fifo_en, fifo_flush, fifo_rd;
  logic        m_valid, m_ready;
  logic [31:0] m_data;
  logic        busy, done, timed_out, overrun;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  i2s_capture_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .vad_trig_en  (vad_trig_en),
    .sample_count (sample_count),
    .timeout      (timeout),
    .vad_flag     (vad_flag),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_rdata   (fifo_rdata),
    .i2s_en       (i2s_en),
    .fifo_en      (fifo_en),
    .fifo_flush   (fifo_flush),
    .fifo_rd      (fifo_rd),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .busy         (busy),
    .done         (done),
    .timed_out    (timed_out),
    .overrun      (overrun)
  );

  // FIFO model: a flush reloads it with the words in pend,
  // standing in for samples arriving right after the flush
  logic [31:0] pend[$];
  logic [31:0] q[$];

  always @(posedge clk) begin
    if (fifo_flush) begin
      q.delete();
      foreach (pend[i]) q.push_back(pend[i]);
    end else if (fifo_rd && q.size() > 0) begin
      void'(q.pop_front());
    end
    fifo_empty <= (q.size() == 0);
    fifo_rdata <= (q.size() > 0) ? q[0] : 32'h0;
  end

  logic [31:0] got[$];
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          fen_cnt = 0;
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'h0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) got.push_back(m_data);
      if (fifo_rd) rd_cnt <= rd_cnt + 1;
      if (done)    done_cnt <= done_cnt + 1;
      if (fifo_en) fen_cnt <= fen_cnt + 1;
      if (prev_stall && m_data !== prev_data)
        stab_err <= stab_err + 1;
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w4 [4];
    int pat [4];
    int b, r, d, f, s, w;

    w4  = '{32'h11, 32'h22, 32'h33, 32'h44};
    pat = '{1, 0, 0, 1};

    rst_n = 1'b0;
    start = 0; abort = 0; vad_trig_en = 0;
    vad_flag = 0; fifo_full = 0; m_ready = 0;
    sample_count = '0; timeout = '0;
    #1;
    chk("rst_busy",   {31'b0, busy},       0);
    chk("rst_i2s_en", {31'b0, i2s_en},     0);
    chk("rst_fen",    {31'b0, fifo_en},    0);
    chk("rst_flush",  {31'b0, fifo_flush}, 0);
    chk("rst_rd",     {31'b0, fifo_rd},    0);
    chk("rst_valid",  {31'b0, m_valid},    0);
    chk("rst_data",   m_data,              0);
    chk("rst_done",   {31'b0, done},       0);
    chk("rst_tmo",    {31'b0, timed_out},  0);
    chk("rst_ovr",    {31'b0, overrun},    0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T1: four words back to back
    pend.delete();
    foreach (w4[i]) pend.push_back(w4[i]);
    sample_count = 16'd4;
    m_ready = 1;
    b = got.size(); d = done_cnt;
    start = 1;
    tick();
    start = 0;
    chk("t1_flush", {31'b0, fifo_flush}, 1);
    chk("t1_busy",  {31'b0, busy},       1);
    tick();
    chk("t1_fen", {31'b0, fifo_en}, 1);
    chk("t1_rd",  {31'b0, fifo_rd}, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_valid", {31'b0, m_valid}, 1);
      chk("t1_data",  m_data,           w4[i]);
    end
    tick();
    chk("t1_done",   {31'b0, done},    1);
    chk("t1_vclr",   {31'b0, m_valid}, 0);
    tick();
    chk("t1_idle",   {31'b0, busy},    0);
    chk("t1_dpulse", {31'b0, done},    0);
    chk("t1_ndone",  done_cnt - d,     1);
    chk("t1_nhs",    got.size() - b,   4);

    // T2: stalled consumer
    b = got.size(); r = rd_cnt; s = stab_err;
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 60; k++) begin
      m_ready = (pat[k % 4] != 0);
      tick();
      if (done) break;
    end
    chk("t2_done", {31'b0, done},   1);
    chk("t2_nhs",  got.size() - b,  4);
    chk("t2_nrd",  rd_cnt - r,      4);
    chk("t2_stab", stab_err - s,    0);
    for (int i = 0; i < 4; i++)
      chk("t2_data", got[b + i], w4[i]);
    m_ready = 1;
    tick();
    chk("t2_idle", {31'b0, busy}, 0);

    // T3: VAD timeout
    vad_trig_en = 1;
    timeout = 24'd10;
    b = got.size(); f = fen_cnt;
    start = 1;
    tick();
    start = 0;
    chk("t3_flush", {31'b0, fifo_flush}, 1);
    w = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (done) break;
      if (i2s_en && !fifo_en && !fifo_flush) w++;
    end
    chk("t3_wait", w,                   10);
    chk("t3_done", {31'b0, done},       1);
    chk("t3_tmo",  {31'b0, timed_out},  1);
    chk("t3_nhs",  got.size() - b,      0);
    chk("t3_fen",  fen_cnt - f,         0);
    tick();
    chk("t3_idle", {31'b0, busy}, 0);

    // T4: VAD arrives 5 cycles after the flush
    pend.delete();
    pend.push_back(32'hA1);
    pend.push_back(32'hA2);
    sample_count = 16'd2;
    b = got.size();
    start = 1;
    tick();
    start = 0;
    tick();
    chk("t4_wait", {31'b0, fifo_en}, 0);
    repeat (4) tick();
    vad_flag = 1;
    tick();
    vad_flag = 0;
    chk("t4_cap", {31'b0, fifo_en},   1);
    chk("t4_tmo", {31'b0, timed_out}, 0);
    wait_done("t4_done");
    chk("t4_nhs", got.size() - b, 2);
    chk("t4_d0",  got[b],         32'hA1);
    chk("t4_d1",  got[b + 1],     32'hA2);
    chk("t4_tmo2", {31'b0, timed_out}, 0);
    tick();

    // T5: abort mid-stream, then a clean one-word run
    vad_trig_en = 0;
    pend.delete();
    pend.push_back(32'h61); pend.push_back(32'h62);
    pend.push_back(32'h63); pend.push_back(32'h64);
    sample_count = 16'd4;
    m_ready = 0;
    d = done_cnt;
    start = 1;
    tick();
    start = 0;
    tick();
    fifo_full = 1;
    tick();
    fifo_full = 0;
    chk("t5_ovr", {31'b0, overrun}, 1);
    m_ready = 1;
    tick();
    chk("t5_valid", {31'b0, m_valid}, 1);
    chk("t5_data",  m_data,           32'h62);
    m_ready = 0;
    abort = 1;
    tick();
    abort = 0;
    chk("t5_abusy",  {31'b0, busy},    0);
    chk("t5_avalid", {31'b0, m_valid}, 0);
    chk("t5_aovr",   {31'b0, overrun}, 1);
    tick();
    chk("t5_nodone", done_cnt - d, 0);
    pend.delete();
    pend.push_back(32'h77);
    sample_count = 16'd1;
    m_ready = 1;
    b = got.size();
    start = 1;
    tick();
    start = 0;
    chk("t5_clr", {31'b0, overrun}, 0);
    wait_done("t5_done");
    chk("t5_nhs", got.size() - b, 1);
    chk("t5_w",   got[b],         32'h77);
    tick();

    // T6: overrun is sticky; zero-length start is ignored
    pend.delete();
    pend.push_back(32'h81);
    pend.push_back(32'h82);
    sample_count = 16'd2;
    start = 1;
    tick();
    start = 0;
    tick();
    fifo_full = 1;
    tick();
    fifo_full = 0;
    wait_done("t6_done");
    chk("t6_ovr", {31'b0, overrun}, 1);
    tick();
    chk("t6_idle", {31'b0, busy},    0);
    chk("t6_ovr2", {31'b0, overrun}, 1);
    sample_count = 16'd0;
    start = 1;
    tick();
    start = 0;
    chk("t6_zbusy",  {31'b0, busy},       0);
    chk("t6_zflush", {31'b0, fifo_flush}, 0);
    chk("t6_zovr",   {31'b0, overrun},    1);
    tick();
    chk("t6_zbusy2", {31'b0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
